// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe register pipeline.
package reg_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Bits needed to count from 0 up to and including depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: a data register plus its valid flag.
// Data moves only when en is high; flush clears the valid flag but leaves the
// data path to follow en; rst loads RESET_VALUE and clears the flag.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             valid_nxt
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // Next-state of the stage outside of reset: shift on en, flush kills valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (en) begin
      data_d  = d;
      valid_d = d_valid;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  // Stage registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= RESET_VALUE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q         = data_q;
  assign q_valid   = valid_q;
  // Exposed so the parent can register an occupancy count that matches the
  // valid flags after the same edge.
  assign valid_nxt = valid_d;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage enabled register pipeline with per-stage valid flags
// and a registered occupancy count.
// Optional feature macro: REG_PIPE_TAPS_EN adds taps/tap_valid outputs that
// expose every stage register directly.
//
// Flow semantics: there is no back-pressure. On every rising edge with en=1
// each stage takes the contents of its predecessor and stage 0 takes
// {d, d_valid}; with en=0 nothing moves. q_valid=1 marks q as carrying a
// value that entered with d_valid=1; invalid entries still travel and appear
// on q with q_valid=0. flush clears every valid flag at that edge.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               DEPTH       = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  input  logic                         flush,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [occ_width(DEPTH)-1:0]  occupancy
`ifdef REG_PIPE_TAPS_EN
  ,
  output logic [WIDTH*DEPTH-1:0]       taps,
  output logic [DEPTH-1:0]             tap_valid
`endif
);

  localparam int OW = occ_width(DEPTH);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_valid_nxt;
  logic [OW-1:0]    occupancy_d, occupancy_q;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [WIDTH-1:0] in_data;
      logic             in_valid;

      if (k == 0) begin : g_head
        assign in_data  = d;
        assign in_valid = d_valid;
      end else begin : g_body
        assign in_data  = stage_data[k-1];
        assign in_valid = stage_valid[k-1];
      end

      reg_pipe_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .d         (in_data),
        .d_valid   (in_valid),
        .q         (stage_data[k]),
        .q_valid   (stage_valid[k]),
        .valid_nxt (stage_valid_nxt[k])
      );

`ifdef REG_PIPE_TAPS_EN
      assign taps[k*WIDTH +: WIDTH] = stage_data[k];
`endif
    end
  endgenerate

  // Count the valid flags the stages will hold after the coming edge.
  always_comb begin
    occupancy_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy_d = occupancy_d + OW'(stage_valid_nxt[k]);
    end
  end

  // Occupancy register, cleared alongside the stages on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign q         = stage_data[DEPTH-1];
  assign q_valid   = stage_valid[DEPTH-1];
  assign occupancy = occupancy_q;

`ifdef REG_PIPE_TAPS_EN
  assign tap_valid = stage_valid;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Testbench for reg_pipe: a DEPTH=4 instance with RESET_VALUE=0x5A and a
// DEPTH=1 instance, driven with directed vectors. Valid shifts on q are
// checked against an expected queue by independent monitors.
module tb_reg_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WIDTH=8, DEPTH=4, RESET_VALUE=0x5A
  logic       rst, en, d_valid, flush;
  logic [7:0] d;
  logic [7:0] q;
  logic       q_valid;
  logic [2:0] occupancy;
`ifdef REG_PIPE_TAPS_EN
  logic [31:0] taps;
  logic [3:0]  tap_valid;
`endif

  // DUT B: WIDTH=8, DEPTH=1, RESET_VALUE=0
  logic       b_rst, b_en, b_d_valid, b_flush;
  logic [7:0] b_d;
  logic [7:0] b_q;
  logic       b_q_valid;
  logic [0:0] b_occupancy;
`ifdef REG_PIPE_TAPS_EN
  logic [7:0] b_taps;
  logic [0:0] b_tap_valid;
`endif

  reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h5A)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .d         (d),
    .d_valid   (d_valid),
    .flush     (flush),
    .q         (q),
    .q_valid   (q_valid),
    .occupancy (occupancy)
`ifdef REG_PIPE_TAPS_EN
    ,
    .taps      (taps),
    .tap_valid (tap_valid)
`endif
  );

  reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00)) u_dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .en        (b_en),
    .d         (b_d),
    .d_valid   (b_d_valid),
    .flush     (b_flush),
    .q         (b_q),
    .q_valid   (b_q_valid),
    .occupancy (b_occupancy)
`ifdef REG_PIPE_TAPS_EN
    ,
    .taps      (b_taps),
    .tap_valid (b_tap_valid)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_a(input string name, input logic [7:0] eq, input logic ev, input logic [2:0] eo);
    chk({name, "_q"}, q, eq);
    chk({name, "_qv"}, q_valid, ev);
    chk({name, "_occ"}, occupancy, eo);
  endtask

  // ---------------- driver tasks ----------------
  // Apply inputs, take one edge, sample 1 time unit later.
  task automatic step(input logic e, input logic [7:0] dd, input logic v,
                      input logic f, input logic r);
    en = e; d = dd; d_valid = v; flush = f; rst = r;
    if (e && v && !f && !r) exp_q.push_back(dd);
    @(posedge clk); #1;
    if (f || r) exp_q.delete();
  endtask

  task automatic step_b(input logic e, input logic [7:0] dd, input logic v,
                        input logic f, input logic r);
    b_en = e; b_d = dd; b_d_valid = v; b_flush = f; b_rst = r;
    if (e && v && !f && !r) exp_b_q.push_back(dd);
    @(posedge clk); #1;
    if (f || r) exp_b_q.delete();
  endtask

  // ---------------- monitors ----------------
  // A new value reaches q only on an edge where the pipe advanced.
  logic adv_a, adv_b;
  always @(posedge clk) begin
    adv_a <= en & ~rst;
    adv_b <= b_en & ~b_rst;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (adv_a === 1'b1 && q_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL mon_a_spurious: got q=0x%0h valid, expected no output", q);
        end else begin
          chk("mon_a_q", q, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (adv_b === 1'b1 && b_q_valid === 1'b1) begin
        if (exp_b_q.size() == 0) begin
          n_checks++;
          $display("FAIL mon_b_spurious: got q=0x%0h valid, expected no output", b_q);
        end else begin
          chk("mon_b_q", b_q, exp_b_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; d = '0; d_valid = 1'b0; flush = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_d = '0; b_d_valid = 1'b0; b_flush = 1'b0;

    // Reset state
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk_a("reset", 8'h5A, 1'b0, 3'd0);
`ifdef REG_PIPE_TAPS_EN
    chk("reset_taps", taps, 32'h5A5A5A5A);
    chk("reset_tap_valid", tap_valid, 4'h0);
`endif

    // Fill with 11,22,33,44: first value at q after its 4th edge
    step(1, 8'h11, 1, 0, 0);
    chk_a("fill1", 8'h5A, 1'b0, 3'd1);
    step(1, 8'h22, 1, 0, 0);
    step(1, 8'h33, 1, 0, 0);
    chk_a("fill3", 8'h5A, 1'b0, 3'd3);
    step(1, 8'h44, 1, 0, 0);
    chk_a("fill4", 8'h11, 1'b1, 3'd4);
`ifdef REG_PIPE_TAPS_EN
    chk("fill4_taps", taps, 32'h11223344);
    chk("fill4_tap_valid", tap_valid, 4'hF);
`endif
    // Drain with invalid zeros
    step(1, 8'h00, 0, 0, 0);
    chk_a("drain1", 8'h22, 1'b1, 3'd3);
    step(1, 8'h00, 0, 0, 0);
    chk_a("drain2", 8'h33, 1'b1, 3'd2);
    step(1, 8'h00, 0, 0, 0);
    chk_a("drain3", 8'h44, 1'b1, 3'd1);
    step(1, 8'h00, 0, 0, 0);
    chk_a("drain4", 8'h00, 1'b0, 3'd0);

    // Stall: A5 loaded, five hold edges, then three advances
    step(1, 8'hA5, 1, 0, 0);
    chk_a("stall_load", 8'h00, 1'b0, 3'd1);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'hFF, 1, 0, 0);
      chk_a("stall_hold", 8'h00, 1'b0, 3'd1);
    end
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    chk_a("stall_resume2", 8'h00, 1'b0, 3'd1);
    step(1, 8'h00, 0, 0, 0);
    chk_a("stall_resume3", 8'hA5, 1'b1, 3'd1);

    // Flush on a full pipe with en=1: valids clear, data still shifts
    step(1, 8'h01, 1, 0, 0);
    step(1, 8'h02, 1, 0, 0);
    step(1, 8'h03, 1, 0, 0);
    step(1, 8'h04, 1, 0, 0);
    chk_a("flush_full", 8'h01, 1'b1, 3'd4);
    step(1, 8'h99, 1, 1, 0);
    chk_a("flush_en", 8'h02, 1'b0, 3'd0);
`ifdef REG_PIPE_TAPS_EN
    chk("flush_en_taps", taps, 32'h02030499);
    chk("flush_en_tap_valid", tap_valid, 4'h0);
`endif
    // Flush with en=0: valids clear, data holds
    step(1, 8'h77, 1, 0, 0);
    chk_a("flush_reload", 8'h03, 1'b0, 3'd1);
    step(0, 8'h55, 1, 1, 0);
    chk_a("flush_hold", 8'h03, 1'b0, 3'd0);
`ifdef REG_PIPE_TAPS_EN
    chk("flush_hold_taps", taps, 32'h03049977);
`endif

    // Mid-stream reset with en=1 and flush=1: reset wins
    step(1, 8'hB1, 1, 0, 0);
    step(1, 8'hB2, 1, 0, 0);
    step(1, 8'hB3, 1, 0, 0);
    step(1, 8'hB4, 1, 0, 0);
    chk_a("rst_full", 8'hB1, 1'b1, 3'd4);
    step(1, 8'hEE, 1, 1, 1);
    chk_a("rst_mid", 8'h5A, 1'b0, 3'd0);
`ifdef REG_PIPE_TAPS_EN
    chk("rst_mid_taps", taps, 32'h5A5A5A5A);
    chk("rst_mid_tap_valid", tap_valid, 4'h0);
`endif
    // First edge after reset operates normally
    step(1, 8'h01, 1, 0, 0);
    chk_a("post_rst", 8'h5A, 1'b0, 3'd1);
`ifdef REG_PIPE_TAPS_EN
    chk("post_rst_taps", taps, 32'h5A5A5A01);
`endif
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    chk_a("post_rst_out", 8'h01, 1'b1, 3'd1);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // DEPTH=1 instance
    step_b(0, 8'h00, 0, 0, 1);
    chk("b_reset_q", b_q, 8'h00);
    chk("b_reset_qv", b_q_valid, 1'b0);
    chk("b_reset_occ", b_occupancy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] v;
      v = 8'(i % 2);
      step_b(1, v, 1, 0, 0);
      chk("b_follow_q", b_q, v);
      chk("b_follow_qv", b_q_valid, 1'b1);
      chk("b_follow_occ", b_occupancy, 1'b1);
    end
    step_b(0, 8'h00, 1, 0, 0);
    step_b(0, 8'h00, 1, 0, 0);
    chk("b_hold_q", b_q, 8'h01);
    chk("b_hold_qv", b_q_valid, 1'b1);
    step_b(1, 8'h07, 0, 0, 0);
    chk("b_invalid_q", b_q, 8'h07);
    chk("b_invalid_qv", b_q_valid, 1'b0);
    chk("b_invalid_occ", b_occupancy, 1'b0);
    step_b(0, 8'h00, 0, 0, 0);

    // Everything expected must have come out
    chk("a_queue_empty", exp_q.size(), 0);
    chk("b_queue_empty", exp_b_q.size(), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
